// File: rtl/exception_ctrl.sv
// MEM-stage exception controller: resolves the CP0 write bypass, picks the winning
// exception, and produces a registered one-cycle flush with a redirect PC.
module exception_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        inst_valid_i,
  input  logic [31:0] pc_i,
  input  logic        is_in_delayslot_i,
  input  logic [7:0]  except_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        cp0_we_i,
  input  logic [4:0]  cp0_waddr_i,
  input  logic [31:0] cp0_wdata_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] newpc_o
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  localparam logic [REG_W-1:0]  ADDR_STATUS = REG_W'(12);
  localparam logic [REG_W-1:0]  ADDR_CAUSE  = REG_W'(13);
  localparam logic [REG_W-1:0]  ADDR_EPC    = REG_W'(14);

  localparam logic [DATA_W-1:0] CODE_INT    = DATA_W'(32'h01);
  localparam logic [DATA_W-1:0] CODE_ADEL   = DATA_W'(32'h04);
  localparam logic [DATA_W-1:0] CODE_ADES   = DATA_W'(32'h05);
  localparam logic [DATA_W-1:0] CODE_SYS    = DATA_W'(32'h08);
  localparam logic [DATA_W-1:0] CODE_BP     = DATA_W'(32'h09);
  localparam logic [DATA_W-1:0] CODE_RI     = DATA_W'(32'h0a);
  localparam logic [DATA_W-1:0] CODE_OV     = DATA_W'(32'h0c);
  localparam logic [DATA_W-1:0] CODE_ERET   = DATA_W'(32'h0e);
  localparam logic [DATA_W-1:0] EXC_VECTOR  = DATA_W'(32'hBFC00380);

  typedef enum logic [1:0] {IDLE, FLUSH, DRAIN} state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] status_eff, cause_eff, epc_eff;
  logic              int_pending, detect;
  logic [DATA_W-1:0] code_sel, bad_sel, newpc_sel;

  logic [DATA_W-1:0] excepttype_d, cur_addr_d, bad_addr_d, newpc_d;
  logic              delayslot_d, flush_d;

  // Status/Cause bits that play no part in interrupt masking
  logic unused_bits;
  assign unused_bits = ^{status_eff[31:16], status_eff[7:2], cause_eff[31:16], cause_eff[7:0]};

  // CP0 values as seen after an mtc0 issued in the same cycle
  always_comb begin
    status_eff = status_i;
    cause_eff  = cause_i;
    epc_eff    = epc_i;
    if (cp0_we_i) begin
      if (cp0_waddr_i == ADDR_STATUS) status_eff = cp0_wdata_i;
      if (cp0_waddr_i == ADDR_EPC)    epc_eff    = cp0_wdata_i;
      if (cp0_waddr_i == ADDR_CAUSE)  cause_eff[9:8] = cp0_wdata_i[9:8];
    end
    int_pending = status_eff[0] & ~status_eff[1] & (|(cause_eff[15:8] & status_eff[15:8]));
  end

  // Fixed-priority exception select; interrupts beat every synchronous cause
  always_comb begin
    code_sel = '0;
    bad_sel  = '0;
    if (int_pending)      code_sel = CODE_INT;
    else if (except_i[0]) begin code_sel = CODE_ADEL; bad_sel = pc_i; end
    else if (except_i[1]) code_sel = CODE_RI;
    else if (except_i[2]) code_sel = CODE_OV;
    else if (except_i[3]) code_sel = CODE_SYS;
    else if (except_i[4]) code_sel = CODE_BP;
    else if (except_i[5]) begin code_sel = CODE_ADEL; bad_sel = mem_addr_i; end
    else if (except_i[6]) begin code_sel = CODE_ADES; bad_sel = mem_addr_i; end
    else if (except_i[7]) code_sel = CODE_ERET;
    newpc_sel = (code_sel == CODE_ERET) ? epc_eff : EXC_VECTOR;
  end

  always_comb begin
    state_d      = state_q;
    excepttype_d = '0;
    flush_d      = 1'b0;
    newpc_d      = '0;
    bad_addr_d   = '0;
    cur_addr_d   = current_inst_addr_o;
    delayslot_d  = is_in_delayslot_o;
    detect       = (state_q == IDLE) & ~stall_i & inst_valid_i & (int_pending | (|except_i));

    case (state_q)
      IDLE: begin
        if (detect) begin
          state_d      = FLUSH;
          excepttype_d = code_sel;
          flush_d      = 1'b1;
          newpc_d      = newpc_sel;
          bad_addr_d   = bad_sel;
          cur_addr_d   = pc_i;
          delayslot_d  = is_in_delayslot_i;
        end
      end
      // Instructions behind the faulting one are being flushed: ignore them
      FLUSH:   state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q             <= IDLE;
      excepttype_o        <= '0;
      flush_o             <= 1'b0;
      newpc_o             <= '0;
      bad_addr_o          <= '0;
      current_inst_addr_o <= '0;
      is_in_delayslot_o   <= 1'b0;
    end else begin
      state_q             <= state_d;
      excepttype_o        <= excepttype_d;
      flush_o             <= flush_d;
      newpc_o             <= newpc_d;
      bad_addr_o          <= bad_addr_d;
      current_inst_addr_o <= cur_addr_d;
      is_in_delayslot_o   <= delayslot_d;
    end
  end

endmodule

// File: doc/exception_ctrl.md
EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 Single clock clk; reset rst is synchronous and active-high; all state updates on posedge clk.
REQ-002 clk  in  1  system clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 stall_i  in  1  MEM stage stalled; no exception is taken while high.
REQ-005 inst_valid_i  in  1  MEM stage holds a real instruction (not a bubble).
REQ-006 pc_i  in  32  PC of the MEM-stage instruction.
REQ-007 is_in_delayslot_i  in  1  MEM-stage instruction is in a delay slot.
REQ-008 except_i  in  8  flags: [0] AdEL-fetch, [1] RI, [2] Ov, [3] Syscall, [4] Break, [5] AdEL-load, [6] AdES-store, [7] ERET.
REQ-009 mem_addr_i  in  32  data address of the MEM-stage load/store.
REQ-010 status_i, cause_i, epc_i  in  32 each  current CP0 Status(12), Cause(13), EPC(14).
REQ-011 cp0_we_i, cp0_waddr_i, cp0_wdata_i  in  1/5/32  CP0 write issued in the same cycle (mtc0 bypass).
REQ-012 excepttype_o  out  32  exception code to CP0; 0 = none.
REQ-013 current_inst_addr_o  out  32  faulting PC to CP0.
REQ-014 is_in_delayslot_o  out  1  delay-slot flag to CP0.
REQ-015 bad_addr_o  out  32  BadVAddr value to CP0.
REQ-016 flush_o  out  1  one-cycle pipeline flush pulse.
REQ-017 newpc_o  out  32  redirect PC, valid while flush_o=1.

Function
REQ-018 Effective CP0 values: if cp0_we_i and cp0_waddr_i==12, Status=cp0_wdata_i; if ==14, EPC=cp0_wdata_i; if ==13, Cause[9:8]=cp0_wdata_i[9:8], other Cause bits from cause_i.
REQ-019 Interrupt pending = Status[0] & ~Status[1] & |(Cause[15:8] & Status[15:8]), effective values.
REQ-020 Detect = state IDLE & ~stall_i & inst_valid_i & (interrupt pending | any except_i bit).
REQ-021 Priority, highest first: interrupt 0x01, AdEL-fetch 0x04, RI 0x0a, Ov 0x0c, Syscall 0x08, Break 0x09, AdEL-load 0x04, AdES-store 0x05, ERET 0x0e; exactly one code selected.
REQ-022 bad_addr_o = pc_i for AdEL-fetch, mem_addr_i for AdEL-load/AdES-store, 0 otherwise.
REQ-023 newpc_o = 32'hBFC00380 for every code except ERET; ERET uses effective EPC.
REQ-024 FSM states IDLE, FLUSH, DRAIN; IDLE->FLUSH on Detect; FLUSH->DRAIN unconditional; DRAIN->IDLE unconditional.
REQ-025 Latency: Detect in cycle N -> excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o, newpc_o registered and flush_o=1 in cycle N+1 (state FLUSH) only.
REQ-026 Outside FLUSH: excepttype_o=0, flush_o=0, newpc_o=0, bad_addr_o=0; current_inst_addr_o and is_in_delayslot_o hold last captured values.
REQ-027 In FLUSH and DRAIN all inputs are ignored; exceptions presented then are discarded (flushed instructions).
REQ-028 stall_i high with pending exception: no capture, stay IDLE, re-evaluate every cycle until stall_i low.
REQ-029 Bubble (inst_valid_i=0): no exception taken, including pending interrupt.
REQ-030 Back-to-back: earliest next Detect is in DRAIN+1, i.e. flush pulses are at least 3 cycles apart.

Reset
REQ-031 rst=1 at a clock edge: state=IDLE, all outputs 0, including mid-FLUSH or mid-DRAIN; no flush pulse emitted in the following cycle.

Verification
REQ-032 except_i=8'h02, pc_i=32'h80001000, valid, no stall -> next cycle excepttype_o=0x0a, flush_o=1, newpc_o=32'hBFC00380, current_inst_addr_o=32'h80001000; following cycle flush_o=0.
REQ-033 except_i=8'h21, mem_addr_i=32'h00000013, pc_i=32'h80000040 -> excepttype_o=0x04, bad_addr_o=32'h80000040 (fetch wins).
REQ-034 Status=32'h00000101, Cause[8] set via cp0_we_i (waddr 13, wdata 32'h100) same cycle, except_i=8'h08 -> excepttype_o=0x01.
REQ-035 except_i=8'h80, epc_i=32'h1000, cp0_we_i=1 waddr 14 wdata 32'h2000 -> newpc_o=32'h2000, excepttype_o=0x0e.
REQ-036 except_i=8'h04 with stall_i=1 for 3 cycles then 0 -> flush_o=1 exactly once, one cycle after stall_i falls; second exception presented during DRAIN -> ignored.
